// File: rtl/rom_loader.sv
// Purpose: writes a byte-stream image into a 2**AW-word memory, then zero-fills the rest of the image.
// Latency: a captured word is written on the first mem_ce after capture; mem_we/mem_a/mem_d are registered.
// Backpressure: one-word hold register; dl_wait is high while it is occupied, and dl_wr is dropped then.
module rom_loader #(
    parameter int DW        = 8,
    parameter int AW        = 14,
    parameter int FILL_ZERO = 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_dl_active,
    input  logic          i_dl_wr,
    input  logic [DW-1:0] i_dl_data,
    output logic          o_dl_wait,
    input  logic          i_mem_ce,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_a,
    output logic [DW-1:0] o_mem_d,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_overflow,
    output logic [AW:0]   o_count
);

    // Image size, last address and unit step, all at counter width.
    localparam logic [AW:0] C_IMG  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] C_LAST = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] C_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_FILL,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_dl_active_q;
    logic            r_pending;
    logic [DW-1:0]   r_hold;
    // One bit wider than the memory address so it can sit at 2**AW
    // after a full image instead of wrapping back to zero.
    logic [AW:0]     r_addr;
    logic [AW:0]     r_count;
    logic            r_overflow;
    logic            r_busy;
    logic            r_done;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_a;
    logic [DW-1:0]   r_mem_d;

    logic            w_rise;
    logic            w_in_load;
    logic            w_room;
    logic            w_accept;
    logic            w_reject_full;
    logic            w_stream_wr;
    logic            w_fill_wr;
    logic            w_pending_nxt;
    logic [AW:0]     w_count_nxt;
    logic            w_fill_needed;

    // A download starts on the low-to-high transition of dl_active.
    assign w_rise        = i_dl_active & ~r_dl_active_q;
    assign w_in_load     = (r_state == S_LOAD);
    assign w_room        = (r_count < C_IMG);

    // Capture and write are mutually exclusive: capture needs the hold
    // register empty, a stream write needs it full.
    assign w_accept      = w_in_load & i_dl_wr & ~r_pending &  w_room;
    assign w_reject_full = w_in_load & i_dl_wr & ~r_pending & ~w_room;
    assign w_stream_wr   = ((r_state == S_LOAD) || (r_state == S_DRAIN)) & r_pending & i_mem_ce;
    assign w_fill_wr     = (r_state == S_FILL) & i_mem_ce;

    // Hold-register occupancy and stream count after this edge; used to
    // decide where to go when the download window closes.
    assign w_pending_nxt = w_accept | (r_pending & ~w_stream_wr);
    assign w_count_nxt   = r_count + (w_stream_wr ? C_ONE : '0);
    assign w_fill_needed = (FILL_ZERO != 0) && (w_count_nxt < C_IMG);

    assign o_dl_wait     = r_pending;
    assign o_mem_we      = r_mem_we;
    assign o_mem_a       = r_mem_a;
    assign o_mem_d       = r_mem_d;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_overflow    = r_overflow;
    assign o_count       = r_count;

    // Previous dl_active for edge detection; cleared by reset so a window
    // already open at reset release still starts a download.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_dl_active_q <= 1'b0;
        end else begin
            r_dl_active_q <= i_dl_active;
        end
    end

    // Loader FSM with registered memory write port and status outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pending  <= 1'b0;
            r_hold     <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_a    <= '0;
            r_mem_d    <= '0;
        end else begin
            r_mem_we <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_rise) begin
                        r_state    <= S_LOAD;
                        r_pending  <= 1'b0;
                        r_addr     <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (w_stream_wr) begin
                        r_mem_we <= 1'b1;
                        r_mem_a  <= r_addr[AW-1:0];
                        r_mem_d  <= r_hold;
                        r_addr   <= r_addr + C_ONE;
                        r_count  <= w_count_nxt;
                    end
                    if (w_accept) begin
                        r_hold <= i_dl_data;
                    end
                    if (w_reject_full) begin
                        r_overflow <= 1'b1;
                    end
                    r_pending <= w_pending_nxt;

                    // Window closed: flush the held word first, otherwise
                    // go straight on to zero-fill or completion.
                    if (!i_dl_active) begin
                        if (w_pending_nxt) begin
                            r_state <= S_DRAIN;
                        end else if (w_fill_needed) begin
                            r_state <= S_FILL;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (w_stream_wr) begin
                        r_mem_we  <= 1'b1;
                        r_mem_a   <= r_addr[AW-1:0];
                        r_mem_d   <= r_hold;
                        r_addr    <= r_addr + C_ONE;
                        r_count   <= w_count_nxt;
                        r_pending <= 1'b0;
                        if (w_fill_needed) begin
                            r_state <= S_FILL;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_FILL: begin
                    // count tracks stream words only, so it is left alone here.
                    if (w_fill_wr) begin
                        r_mem_we <= 1'b1;
                        r_mem_a  <= r_addr[AW-1:0];
                        r_mem_d  <= '0;
                        r_addr   <= r_addr + C_ONE;
                        if (r_addr == C_LAST) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          dl_active;
    logic          dl_wr;
    logic [DW-1:0] dl_data;
    logic          dl_wait;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected memory writes as {addr[3:0], data[7:0]}: exp_q is consumed by
    // the compare process, exp_log keeps the whole download for pinning.
    logic [11:0] exp_q[$];
    logic [11:0] exp_log[$];
    int          mcount;
    int          ce_mode = 0;

    rom_loader #(.DW(DW), .AW(AW), .FILL_ZERO(1)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_dl_active (dl_active),
        .i_dl_wr     (dl_wr),
        .i_dl_data   (dl_data),
        .o_dl_wait   (dl_wait),
        .i_mem_ce    (mem_ce),
        .o_mem_we    (mem_we),
        .o_mem_a     (mem_a),
        .o_mem_d     (mem_d),
        .o_busy      (busy),
        .o_done      (done),
        .o_overflow  (overflow),
        .o_count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mem_ce pattern: 0 = every cycle, 1 = one cycle in four, else never.
    initial begin
        int ph;
        ph = 0;
        mem_ce = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ce_mode)
                0:       mem_ce = 1'b1;
                1:       mem_ce = ((ph % 4) == 0);
                default: mem_ce = 1'b0;
            endcase
            ph++;
        end
    end

    // Compare process: every observed write must follow a mem_ce cycle and
    // match the next expected (address, data) pair.
    initial begin
        logic        ce_seen;
        logic [11:0] e;
        forever begin
            @(posedge clk);
            ce_seen = mem_ce;
            @(negedge clk);
            if (mem_we === 1'b1) begin
                chk("write_needs_mem_ce", {31'd0, ce_seen}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got a=%0h d=%0h, expected no write", mem_a, mem_d);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", {28'd0, mem_a}, {20'd0, e[11:8]});
                    chk("write_data", {24'd0, mem_d}, {24'd0, e[7:0]});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic [3:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
        exp_log.push_back({a, d});
    endtask

    task automatic start_dl;
        exp_log.delete();
        mcount    = 0;
        dl_active = 1'b1;
        tick;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_cleared", {31'd0, done}, 32'd0);
    endtask

    // Offer one byte as soon as dl_wait is low.
    task automatic send(input logic [7:0] b);
        int g;
        g = 0;
        while (dl_wait === 1'b1 && g < 100) begin
            tick;
            g++;
        end
        if (g >= 100) chk("dl_wait_timeout", {31'd0, dl_wait}, 32'd0);
        dl_wr   = 1'b1;
        dl_data = b;
        if (mcount < 16) begin
            push_exp(4'(mcount), b);
            mcount++;
            tick;
            dl_wr = 1'b0;
            chk("dl_wait_after_capture", {31'd0, dl_wait}, 32'd1);
        end else begin
            tick;
            dl_wr = 1'b0;
            chk("overflow_on_extra_word", {31'd0, overflow}, 32'd1);
        end
    endtask

    // Close the window; untouched addresses are then expected as zeros.
    task automatic stop_dl;
        dl_active = 1'b0;
        for (int a = mcount; a < 16; a++) push_exp(4'(a), 8'h00);
    endtask

    task automatic wait_done(input int exp_count, input logic exp_ovf);
        int g;
        g = 0;
        while (done !== 1'b1 && g < 500) begin
            tick;
            g++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
        tick;
        chk("all_writes_seen", exp_q.size(), 32'd0);
        chk("final_count", {27'd0, count}, exp_count);
        chk("final_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        chk("busy_low_in_done", {31'd0, busy}, 32'd0);
        repeat (3) tick;
        chk("done_holds", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int g;
        rst       = 1'b1;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        dl_data   = '0;
        ce_mode   = 0;

        // Reset state with dl_active low, then 20 idle cycles.
        tick;
        tick;
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_a", {28'd0, mem_a}, 32'd0);
        chk("rst_mem_d", {24'd0, mem_d}, 32'd0);
        chk("rst_dl_wait", {31'd0, dl_wait}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        rst = 1'b0;
        repeat (20) begin
            tick;
            chk("idle_no_write", {31'd0, mem_we}, 32'd0);
            chk("idle_not_busy", {31'd0, busy}, 32'd0);
        end

        // Three-byte stream, mem_ce always high, zero-fill of 3..15.
        ce_mode = 0;
        start_dl;
        send(8'hA5);
        send(8'h5A);
        send(8'hFF);
        stop_dl;
        chk("model_size_a", exp_log.size(), 32'd16);
        chk("model_a0", {20'd0, exp_log[0]}, 32'h0A5);
        chk("model_a1", {20'd0, exp_log[1]}, 32'h15A);
        chk("model_a2", {20'd0, exp_log[2]}, 32'h2FF);
        chk("model_a3", {20'd0, exp_log[3]}, 32'h300);
        chk("model_a15", {20'd0, exp_log[15]}, 32'hF00);
        wait_done(3, 1'b0);

        // Eight bytes at max rate with mem_ce one cycle in four.
        ce_mode = 1;
        start_dl;
        for (int i = 0; i < 8; i++) send(8'(8'h30 + i));
        stop_dl;
        chk("model_b7", {20'd0, exp_log[7]}, 32'h737);
        chk("model_b8", {20'd0, exp_log[8]}, 32'h800);
        wait_done(8, 1'b0);

        // Seventeen bytes 00..10: full image, overflow, no fill.
        ce_mode = 0;
        start_dl;
        for (int i = 0; i < 17; i++) send(8'(i));
        stop_dl;
        chk("model_size_c", exp_log.size(), 32'd16);
        chk("model_c15", {20'd0, exp_log[15]}, 32'hF0F);
        wait_done(16, 1'b1);

        // dl_wr while dl_wait high is dropped.
        ce_mode = 1;
        start_dl;
        send(8'h01);
        send(8'h02);
        chk("wait_high_before_drop", {31'd0, dl_wait}, 32'd1);
        dl_wr   = 1'b1;
        dl_data = 8'hEE;
        tick;
        dl_wr = 1'b0;
        g = 0;
        while (dl_wait === 1'b1 && g < 50) begin
            tick;
            g++;
        end
        chk("count_after_drop", {27'd0, count}, 32'd2);
        send(8'h03);
        stop_dl;
        chk("model_d2", {20'd0, exp_log[2]}, 32'h203);
        wait_done(3, 1'b0);

        // Reset while zero-filling address 7.
        ce_mode = 0;
        start_dl;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        stop_dl;
        g = 0;
        while (!(mem_we === 1'b1 && mem_a === 4'd7) && g < 200) begin
            tick;
            g++;
        end
        chk("reached_fill_addr7", {28'd0, mem_a}, 32'd7);
        rst = 1'b1;
        tick;
        exp_q.delete();
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_count", {27'd0, count}, 32'd0);
        rst = 1'b0;
        repeat (20) tick;
        chk("abort_still_idle", {31'd0, busy}, 32'd0);

        // dl_active already high at reset release starts a download.
        rst       = 1'b1;
        dl_active = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        exp_log.delete();
        mcount = 0;
        tick;
        chk("load_after_reset_release", {31'd0, busy}, 32'd1);
        send(8'h77);
        stop_dl;
        wait_done(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The block SHALL provide parameter DW, default 8, memory data width in bits.
REQ-002 The block SHALL provide parameter AW, default 14, memory address width; image size is 2**AW words.
REQ-003 The block SHALL provide parameter FILL_ZERO, default 1; when 1, addresses not covered by the stream are written with zero after the download ends.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 dl_active  input  1  download window; high for the duration of one image transfer.
REQ-007 dl_wr  input  1  one-cycle strobe: dl_data valid.
REQ-008 dl_data  input  DW  stream word.
REQ-009 dl_wait  output  1  backpressure; a dl_wr seen while high is dropped.
REQ-010 mem_ce  input  1  memory write slot; a write is issued only in a cycle following mem_ce high.
REQ-011 mem_we  output  1  registered one-cycle write strobe.
REQ-012 mem_a  output  AW  write address, valid while mem_we high.
REQ-013 mem_d  output  DW  write data, valid while mem_we high.
REQ-014 busy  output  1  high in LOAD, DRAIN or FILL.
REQ-015 done  output  1  high in DONE.
REQ-016 overflow  output  1  sticky: stream exceeded 2**AW words.
REQ-017 count  output  AW+1  stream words written this download, 0..2**AW.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, DRAIN, FILL, DONE.
REQ-019 A rising edge of dl_active (registered previous value, reset to 0) from IDLE or DONE SHALL enter LOAD and clear address counter, count, overflow and done.
REQ-020 In LOAD, dl_wr with dl_wait low and count < 2**AW SHALL capture dl_data into a one-word hold register and set pending; dl_wait SHALL equal pending (registered), high from the next cycle.
REQ-021 When pending and mem_ce are high in cycle N, edge N+1 SHALL drive mem_we=1, mem_a=address counter, mem_d=hold, clear pending, increment address counter and count; mem_we SHALL return low at N+2 unless another write is issued.
REQ-022 Simultaneous dl_wr and mem_ce with pending low SHALL capture only; the write waits for a later mem_ce.
REQ-023 dl_wr while dl_wait high, or outside LOAD, SHALL be ignored with no state change.
REQ-024 dl_wr with count = 2**AW SHALL set overflow and drop the word; address counter SHALL NOT wrap.
REQ-025 dl_active low in LOAD SHALL enter DRAIN if pending, else proceed per REQ-026.
REQ-026 After the last stream write (from LOAD or DRAIN): FILL if FILL_ZERO=1 and count < 2**AW, else DONE.
REQ-027 In FILL, each mem_ce SHALL issue one write of data 0 at the address counter, incrementing it; after address 2**AW-1 is written the FSM SHALL enter DONE; count SHALL NOT change in FILL.
REQ-028 A new dl_active rising edge during LOAD, DRAIN or FILL SHALL be ignored.
REQ-029 done SHALL stay high in DONE until the next dl_active rising edge.
REQ-030 At most one memory write SHALL occur per mem_ce, and none outside LOAD/DRAIN/FILL.

Reset
REQ-031 reset SHALL force IDLE, pending=0, address counter=0, and mem_we, mem_a, mem_d, dl_wait, busy, done, overflow, count all 0 at the next edge.
REQ-032 Reset mid-operation SHALL abort the transfer with no further writes; dl_active high at reset release SHALL be seen as a rising edge and start LOAD.

Verification (bench AW=4, DW=8)
REQ-033 Reset with dl_active low -> all outputs 0, no mem_we for 20 cycles.
REQ-034 FILL_ZERO=1, mem_ce always high, stream A5,5A,FF then dl_active low -> writes (0,A5),(1,5A),(2,FF), then data 00 at addresses 3..15, done=1, count=3, overflow=0.
REQ-035 mem_ce high one cycle in four, 8 bytes at max rate -> dl_wait high each byte until written, all 8 bytes in order at addresses 0..7, none lost.
REQ-036 17 bytes 00..10 -> addresses 0..15 hold 00..0F, overflow=1, count=16, no FILL writes, done=1.
REQ-037 dl_wr pulsed while dl_wait high -> word dropped, count unchanged, next accepted word written at next address.
REQ-038 reset asserted during FILL at address 7 -> mem_we low from next cycle, done=0, busy=0, no further writes.
